// File: rtl/mac_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter_if
// Purpose : 100M MAC user-side TX beat bus (Clk_user domain). One instance is
//           used per requester and one for the MAC-facing side of the arbiter.
// Signals : wa   - write-allowed, from sink to source
//           wr   - write strobe, source to sink
//           data - 32-bit beat data
//           be   - byte enable, big endian
//           sop  - first beat of a packet
//           eop  - last beat of a packet
// Modports: master - the side that sources beats (drives wr/data/be/sop/eop)
//           slave  - the side that sinks beats (drives wa)
// -----------------------------------------------------------------------------
interface mac_tx_arbiter_if;
    logic        wa;
    logic        wr;
    logic [31:0] data;
    logic [1:0]  be;
    logic        sop;
    logic        eop;

    modport master (input wa, output wr, output data, output be, output sop, output eop);
    modport slave  (output wa, input wr, input data, input be, input sop, input eop);
endinterface

// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
// Purpose : Packet-granular two-requester arbiter in front of the 100M MAC user
//           TX interface. A grant is held from sop to eop so packets never
//           interleave. Round-robin port selection, a watchdog that reclaims
//           grants from requesters that never start a packet, and per-port
//           packet counters for the status registers.
// Build   : define MAC_TX_ARB_PRIO_EN to give port 0 strict priority instead of
//           round-robin; watchdog, counters and error flags are unchanged.
// Ports   : Clk_user       - user clock (single domain)
//           Reset          - synchronous, active-high
//           Req0/Req1      - requester has a packet pending
//           Gnt0/Gnt1      - registered grant, at most one high
//           tx0/tx1        - requester beat buses (slave side)
//           tx_mac         - MAC beat bus (master side)
//           Pkt_cnt0/1     - packets forwarded per port, wrapping
//           Timeout_err    - one-cycle pulse when the watchdog revokes a grant
//           Proto_err      - one-cycle pulse when a beat without sop is dropped
// -----------------------------------------------------------------------------
module mac_tx_arbiter #(
    parameter int TMO_CYCLES = 255,
    parameter int TMO_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic             Clk_user,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    output logic             Gnt0,
    output logic             Gnt1,
    mac_tx_arbiter_if.slave  tx0,
    mac_tx_arbiter_if.slave  tx1,
    mac_tx_arbiter_if.master tx_mac,
    output logic [CNT_W-1:0] Pkt_cnt0,
    output logic [CNT_W-1:0] Pkt_cnt1,
    output logic             Timeout_err,
    output logic             Proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    // Watchdog fires on the cycle its count would reach TMO_CYCLES, so the
    // grant is held for exactly TMO_CYCLES idle cycles.
    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TMO_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             in_pkt_q, in_pkt_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
    logic             timeout_err_q, timeout_err_d;
    logic             proto_err_q, proto_err_d;

    // Selected-port view of the requester buses
    logic        granted;
    logic        sel_port;
    logic        p_wr, p_sop, p_eop;
    logic [31:0] p_data;
    logic [1:0]  p_be;
    logic        req_own, req_oth;
    logic        fwd_ok, mac_wr, accept, proto_hit;

    // Arbitration among pending requests; `last` is the port served most
    // recently and loses a tie under round-robin.
    function automatic state_e pick(input logic r0, input logic r1, input logic last);
        state_e tie_winner;
        tie_winner = last ? GNT0 : GNT1;
`ifdef MAC_TX_ARB_PRIO_EN
        tie_winner = GNT0;
`endif
        if (r0 && r1)
            return tie_winner;
        else if (r0)
            return GNT0;
        else if (r1)
            return GNT1;
        return IDLE;
    endfunction

    // Datapath mux and beat qualification
    always_comb begin
        granted   = (state_q != IDLE);
        sel_port  = (state_q == GNT1);
        p_wr      = sel_port ? tx1.wr   : tx0.wr;
        p_sop     = sel_port ? tx1.sop  : tx0.sop;
        p_eop     = sel_port ? tx1.eop  : tx0.eop;
        p_data    = sel_port ? tx1.data : tx0.data;
        p_be      = sel_port ? tx1.be   : tx0.be;
        req_own   = sel_port ? Req1 : Req0;
        req_oth   = sel_port ? Req0 : Req1;
        // A beat outside a packet is only forwarded if it opens one.
        fwd_ok    = in_pkt_q | p_sop;
        mac_wr    = granted & p_wr & fwd_ok;
        accept    = mac_wr & tx_mac.wa;
        proto_hit = granted & p_wr & tx_mac.wa & ~in_pkt_q & ~p_sop;
    end

    assign tx_mac.wr   = mac_wr;
    assign tx_mac.data = granted ? p_data : 32'd0;
    assign tx_mac.be   = granted ? p_be   : 2'd0;
    assign tx_mac.sop  = granted & p_sop;
    assign tx_mac.eop  = granted & p_eop;
    // The requester still sees wa=1 on a dropped beat; only its grant gates it.
    assign tx0.wa      = (state_q == GNT0) & tx_mac.wa;
    assign tx1.wa      = (state_q == GNT1) & tx_mac.wa;

    assign Gnt0        = (state_q == GNT0);
    assign Gnt1        = (state_q == GNT1);
    assign Pkt_cnt0    = pkt_cnt0_q;
    assign Pkt_cnt1    = pkt_cnt1_q;
    assign Timeout_err = timeout_err_q;
    assign Proto_err   = proto_err_q;

    // Next-state, packet tracking, watchdog and counters
    always_comb begin
        // NOTE: every variable gets a default here first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        last_d        = last_q;
        in_pkt_d      = in_pkt_q;
        wdog_d        = wdog_q;
        pkt_cnt0_d    = pkt_cnt0_q;
        pkt_cnt1_d    = pkt_cnt1_q;
        timeout_err_d = 1'b0;
        proto_err_d   = proto_hit;

        case (state_q)
            IDLE: begin
                state_d = pick(Req0, Req1, last_q);
                wdog_d  = '0;   // grant entry starts from a clear watchdog
            end
            GNT0, GNT1: begin
                if (accept) begin
                    wdog_d = '0;
                    if (p_sop)
                        in_pkt_d = 1'b1;
                    if (p_eop) begin
                        in_pkt_d = 1'b0;
                        last_d   = sel_port;
                        if (sel_port)
                            pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                        else
                            pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                        // Hand over without a dead cycle only if the other
                        // port is waiting; otherwise go back to IDLE.
                        state_d = req_oth ? pick(Req0, Req1, sel_port) : IDLE;
                    end
                end else if (!in_pkt_q) begin
                    if (!req_own) begin
                        state_d = IDLE;
                        wdog_d  = '0;
                    end else if (wdog_q == WDOG_LAST) begin
                        timeout_err_d = 1'b1;
                        last_d        = sel_port;
                        state_d       = IDLE;
                        wdog_d        = '0;
                    end else begin
                        wdog_d = wdog_q + TMO_W'(1);
                    end
                end
                // Mid-packet stalls hold the watchdog: no timeout inside a packet.
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge Clk_user) begin
        if (Reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;   // port 0 wins the first tie
            in_pkt_q      <= 1'b0;
            wdog_q        <= '0;
            pkt_cnt0_q    <= '0;
            pkt_cnt1_q    <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            in_pkt_q      <= in_pkt_d;
            wdog_q        <= wdog_d;
            pkt_cnt0_q    <= pkt_cnt0_d;
            pkt_cnt1_q    <= pkt_cnt1_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_arbiter
// Purpose : Self-checking bench for mac_tx_arbiter. A packet-level model of the
//           arbiter (current owner, last served port, idle time of the current
//           grant, packet counts) predicts every output each cycle; directed
//           scenarios add hand-computed literal expectations.
// Build   : define MAC_TX_ARB_PRIO_EN for the strict-priority variant; the
//           model and the priority scenario follow the same macro.
// -----------------------------------------------------------------------------
module tb_mac_tx_arbiter;
    localparam int TMO   = 20;
    localparam int TMO_W = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        req  [2];
    logic        wr   [2];
    logic [31:0] data [2];
    logic [1:0]  be   [2];
    logic        sop  [2];
    logic        eop  [2];
    logic        mac_wa;

    logic             gnt0, gnt1;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             tmo_err, proto_err;

    mac_tx_arbiter_if u_tx0 ();
    mac_tx_arbiter_if u_tx1 ();
    mac_tx_arbiter_if u_mac ();

    assign u_tx0.wr   = wr[0];
    assign u_tx0.data = data[0];
    assign u_tx0.be   = be[0];
    assign u_tx0.sop  = sop[0];
    assign u_tx0.eop  = eop[0];
    assign u_tx1.wr   = wr[1];
    assign u_tx1.data = data[1];
    assign u_tx1.be   = be[1];
    assign u_tx1.sop  = sop[1];
    assign u_tx1.eop  = eop[1];
    assign u_mac.wa   = mac_wa;

    mac_tx_arbiter #(.TMO_CYCLES(TMO), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .Clk_user    (clk),
        .Reset       (rst),
        .Req0        (req[0]),
        .Req1        (req[1]),
        .Gnt0        (gnt0),
        .Gnt1        (gnt1),
        .tx0         (u_tx0),
        .tx1         (u_tx1),
        .tx_mac      (u_mac),
        .Pkt_cnt0    (cnt0),
        .Pkt_cnt1    (cnt1),
        .Timeout_err (tmo_err),
        .Proto_err   (proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Packet-level model
    // ------------------------------------------------------------------
    int m_owner;        // -1: nobody holds the MAC, else the port number
    bit m_last;         // port served most recently
    bit m_inpkt;        // owner is between an accepted sop and its eop
    int m_idle;         // idle cycles of the current grant before a packet starts
    int m_cnt [2];
    bit m_tmo, m_proto;
    bit m_valid = 1'b0;
    int mp;
    bit mfwd, macc;

    function automatic int choose(input bit r0, input bit r1, input bit lst);
        if (r0 && r1) begin
`ifdef MAC_TX_ARB_PRIO_EN
            return 0;
`else
            return lst ? 0 : 1;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_last = 1'b1; m_inpkt = 1'b0; m_idle = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_tmo = 1'b0; m_proto = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_tmo = 1'b0;
            m_proto = 1'b0;
            if (m_owner < 0) begin
                m_owner = choose(req[0], req[1], m_last);
                m_idle = 0;
            end else begin
                mp = m_owner;
                mfwd = m_inpkt || sop[mp];
                macc = wr[mp] && mfwd && mac_wa;
                m_proto = wr[mp] && mac_wa && !m_inpkt && !sop[mp];
                if (macc) begin
                    m_idle = 0;
                    if (sop[mp]) m_inpkt = 1'b1;
                    if (eop[mp]) begin
                        m_inpkt = 1'b0;
                        m_cnt[mp] = (m_cnt[mp] + 1) % (1 << CNT_W);
                        m_last = (mp == 1);
                        m_owner = req[1-mp] ? choose(req[0], req[1], m_last) : -1;
                    end
                end else if (!m_inpkt) begin
                    if (!req[mp]) begin
                        m_owner = -1;
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            m_tmo = 1'b1;
                            m_last = (mp == 1);
                            m_owner = -1;
                            m_idle = 0;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every output, every cycle, on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            if (m_owner >= 0) begin
                check("mac_wr",   u_mac.wr,   wr[m_owner] && (m_inpkt || sop[m_owner]));
                check("mac_data", u_mac.data, data[m_owner]);
                check("mac_be",   u_mac.be,   be[m_owner]);
                check("mac_sop",  u_mac.sop,  sop[m_owner]);
                check("mac_eop",  u_mac.eop,  eop[m_owner]);
            end else begin
                check("mac_wr_idle",   u_mac.wr,   0);
                check("mac_data_idle", u_mac.data, 0);
                check("mac_be_idle",   u_mac.be,   0);
                check("mac_sop_idle",  u_mac.sop,  0);
                check("mac_eop_idle",  u_mac.eop,  0);
            end
            check("gnt0",      gnt0,      m_owner == 0);
            check("gnt1",      gnt1,      m_owner == 1);
            check("tx0_wa",    u_tx0.wa,  (m_owner == 0) && mac_wa);
            check("tx1_wa",    u_tx1.wa,  (m_owner == 1) && mac_wa);
            check("pkt_cnt0",  cnt0,      m_cnt[0]);
            check("pkt_cnt1",  cnt1,      m_cnt[1]);
            check("tmo_err",   tmo_err,   m_tmo);
            check("proto_err", proto_err, m_proto);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? gnt0 : gnt1;
    endfunction

    task automatic wait_gnt(input int p, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gnt_of(p)) return;
        end
        bound_fail(name);
    endtask

    // Sends npkts packets of nbeats each on port p, holding Req across them.
    task automatic run_port(input int p, input int npkts, input int nbeats);
        bit acc;
        int guard;
        req[p] = 1'b1;
        for (int k = 0; k < npkts; k++) begin
            for (int b = 0; b < nbeats; b++) begin
                wr[p]   = 1'b1;
                sop[p]  = (b == 0);
                eop[p]  = (b == nbeats - 1);
                data[p] = {4'(p), 12'(k), 16'(b)};
                be[p]   = (b == nbeats - 1) ? 2'b01 : 2'b00;
                acc = 1'b0;
                guard = 0;
                while (!acc) begin
                    @(negedge clk);
                    acc = gnt_of(p) && mac_wa;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (guard > 500) begin
                        bound_fail("run_port");
                        return;
                    end
                end
            end
        end
        req[p] = 1'b0; wr[p] = 1'b0; sop[p] = 1'b0; eop[p] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int n;
    int n_idle;

    initial begin
        rst = 1'b1;
        mac_wa = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; wr[i] = 0; data[i] = 0; be[i] = 0; sop[i] = 0; eop[i] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_gnt0", gnt0, 0);
        check("rst_mac_wr", u_mac.wr, 0);
        check("rst_cnt0", cnt0, 0);
        tick();

        // 1: single 3-beat packet on port 0
        fork
            run_port(0, 1, 3);
            begin
                @(negedge clk);
                check("t1_gnt_before", gnt0, 0);
                @(negedge clk);
                check("t1_gnt_after", gnt0, 1);
                check("t1_first_sop", u_mac.sop, 1);
            end
        join
        @(negedge clk);
        check("t1_cnt0", cnt0, 1);
        check("t1_back_idle", gnt0 | gnt1, 0);
        tick();

        // 2: both ports, 4 x 2-beat packets each; port 1 first since 0 was last
        fork
            run_port(0, 4, 2);
            run_port(1, 4, 2);
            begin
                wait_gnt(1, "t2_first_gnt");
                n_idle = 0;
                for (int i = 0; i < 16; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!(gnt0 || gnt1)) n_idle++;
                    check("t2_owner_seq", gnt1, ((i / 2) % 2) == 0);
                end
                check("t2_idle_cycles", n_idle, 0);
            end
        join
        @(negedge clk);
        check("t2_cnt0", cnt0, 5);
        check("t2_cnt1", cnt1, 4);
        tick();

        // 3: 10 cycles of MAC backpressure in the middle of a port-1 packet
        fork
            run_port(1, 1, 4);
            begin
                wait_gnt(1, "t3_gnt");
                tick();
                tick();
                mac_wa = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    check("t3_tx0_wa", u_tx0.wa, 0);
                    check("t3_tx1_wa", u_tx1.wa, 0);
                    check("t3_tmo", tmo_err, 0);
                    check("t3_data_held", u_mac.data, 32'h1000_0002);
                    tick();
                end
                mac_wa = 1'b1;
            end
        join
        @(negedge clk);
        check("t3_cnt1", cnt1, 5);
        tick();

        // 4: port 0 granted but silent; watchdog hands over to port 1
        req[0] = 1'b1;
        req[1] = 1'b1;
        wait_gnt(0, "t4_gnt0");
        n = 0;
        begin : t4_wait
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                n++;
                if (tmo_err) disable t4_wait;
            end
            bound_fail("t4_tmo_wait");
        end
        check("t4_tmo_latency", n, TMO);
        @(negedge clk);
        check("t4_gnt1_next", gnt1, 1);
        check("t4_tmo_one_cycle", tmo_err, 0);
        tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        tick();
        tick();

        // 5: beat without sop is dropped, then a sop+eop beat goes through
        req[0] = 1'b1;
        wait_gnt(0, "t5_gnt0");
        tick();
        wr[0] = 1'b1; sop[0] = 1'b0; eop[0] = 1'b0; data[0] = 32'hDEAD_0001;
        @(negedge clk);
        check("t5_drop_wr", u_mac.wr, 0);
        check("t5_drop_wa", u_tx0.wa, 1);
        tick();
        sop[0] = 1'b1; eop[0] = 1'b1; data[0] = 32'h0000_BEEF;
        @(negedge clk);
        check("t5_proto_pulse", proto_err, 1);
        check("t5_fwd_wr", u_mac.wr, 1);
        check("t5_fwd_data", u_mac.data, 32'h0000_BEEF);
        tick();
        wr[0] = 1'b0; sop[0] = 1'b0; eop[0] = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("t5_proto_clear", proto_err, 0);
        check("t5_cnt0", cnt0, 6);
        tick();

        // 6: counter wrap with 12 single-beat packets on port 1 (CNT_W=4)
        run_port(1, 12, 1);
        @(negedge clk);
        check("t6_cnt1_wrap", cnt1, 1);
        tick();

`ifdef MAC_TX_ARB_PRIO_EN
        // 7: strict priority, port 0 keeps the MAC for three packets
        fork
            run_port(0, 3, 2);
            run_port(1, 1, 2);
            begin
                wait_gnt(1, "t7_gnt1");
                check("t7_cnt0_before_gnt1", cnt0, 9);
            end
        join
        @(negedge clk);
        check("t7_cnt1", cnt1, 2);
        tick();
`endif

        // 8: reset in the middle of a packet
        req[0] = 1'b1;
        wr[0] = 1'b1; sop[0] = 1'b1; eop[0] = 1'b0; data[0] = 32'hCAFE_0000;
        wait_gnt(0, "t8_gnt0");
        tick();
        sop[0] = 1'b0; data[0] = 32'hCAFE_0001;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t8_gnt0", gnt0, 0);
        check("t8_mac_wr", u_mac.wr, 0);
        check("t8_mac_eop", u_mac.eop, 0);
        check("t8_tx0_wa", u_tx0.wa, 0);
        check("t8_cnt0", cnt0, 0);
        check("t8_cnt1", cnt1, 0);
        tick();
        req[0] = 1'b0; wr[0] = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
